// File: rtl/led_page_scheduler.sv
// Rotates up to four display pages onto a 7-segment driver, with a timed alert
// overlay that pre-empts the rotation and then returns to the page it interrupted.
module led_page_scheduler #(
  parameter int unsigned PAGE_CYCLES  = 50000000,
  parameter int unsigned ALERT_CYCLES = 20000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   src_valid,
  input  logic [127:0] src_value,
  input  logic [31:0]  src_enable,
  input  logic         alert_req,
  input  logic [31:0]  alert_value,
  input  logic [7:0]   alert_enable,
  input  logic         hold,
  input  logic         next,
  output logic [31:0]  value,
  output logic [7:0]   enable,
  output logic [1:0]   cur_src,
  output logic         alert_active,
  output logic         alert_ack
);

  localparam int unsigned PW = (PAGE_CYCLES  > 1) ? $clog2(PAGE_CYCLES)  : 1;
  localparam int unsigned AW = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_CYCLES - 1);
  localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALERT = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [1:0]    cur_n;
  logic [PW-1:0] page_cnt, page_n;
  logic [AW-1:0] alert_cnt, alert_n;
  logic [31:0]   alert_val_q, alert_val_n;
  logic [7:0]    alert_en_q, alert_en_n;
  logic          ack_n;
  logic [31:0]   value_n;
  logic [7:0]    enable_n;

  logic          any_valid;
  logic [1:0]    first_src;
  logic [1:0]    adv_src;
  logic [1:0]    rr_idx;

  assign any_valid = |src_valid;

  // Lowest-index valid source, and next valid source in round-robin order after
  // cur_src (falls back to cur_src itself when it is the only valid one).
  always_comb begin
    first_src = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (src_valid[i]) first_src = 2'(i);
    end
    adv_src = cur_src;
    rr_idx  = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      rr_idx = cur_src + 2'(k);
      if (src_valid[rr_idx]) adv_src = rr_idx;
    end
  end

  // Next-state logic; an alert request pre-empts every page event.
  always_comb begin
    state_n     = state;
    cur_n       = cur_src;
    page_n      = page_cnt;
    alert_n     = alert_cnt;
    alert_val_n = alert_val_q;
    alert_en_n  = alert_en_q;
    ack_n       = 1'b0;

    if (alert_req) begin
      state_n     = ALERT;
      alert_n     = '0;
      alert_val_n = alert_value;
      alert_en_n  = alert_enable;
      ack_n       = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            state_n = SHOW;
            cur_n   = first_src;
            page_n  = '0;
          end
        end
        SHOW: begin
          if (!src_valid[cur_src] || next || (!hold && page_cnt == PAGE_LAST)) begin
            page_n = '0;
            if (any_valid) cur_n = adv_src;
            else           state_n = IDLE;
          end else if (!hold) begin
            page_n = page_cnt + PW'(1);
          end
        end
        ALERT: begin
          if (alert_cnt == ALERT_LAST) begin
            alert_n = '0;
            page_n  = '0;
            if (src_valid[cur_src]) begin
              state_n = SHOW;
            end else if (any_valid) begin
              state_n = SHOW;
              cur_n   = first_src;
            end else begin
              state_n = IDLE;
            end
          end else begin
            alert_n = alert_cnt + AW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Display payload for the state being entered, so outputs line up with the state.
  always_comb begin
    value_n  = 32'd0;
    enable_n = 8'd0;
    unique case (state_n)
      SHOW: begin
        value_n  = src_value[{cur_n, 5'd0} +: 32];
        enable_n = src_enable[{cur_n, 3'd0} +: 8];
      end
      ALERT: begin
        value_n  = alert_val_n;
        enable_n = alert_en_n;
      end
      default: begin
        value_n  = 32'd0;
        enable_n = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur_src      <= 2'd0;
      page_cnt     <= '0;
      alert_cnt    <= '0;
      alert_val_q  <= 32'd0;
      alert_en_q   <= 8'd0;
      value        <= 32'd0;
      enable       <= 8'd0;
      alert_active <= 1'b0;
      alert_ack    <= 1'b0;
    end else begin
      state        <= state_n;
      cur_src      <= cur_n;
      page_cnt     <= page_n;
      alert_cnt    <= alert_n;
      alert_val_q  <= alert_val_n;
      alert_en_q   <= alert_en_n;
      value        <= value_n;
      enable       <= enable_n;
      alert_active <= (state_n == ALERT);
      alert_ack    <= ack_n;
    end
  end

endmodule
